// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative MUL/MULH/DIV/REM with valid/ready write-back.
// Two's-complement operation is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic              kill,
  output logic              busy,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]     cnt;
  logic              fin;
  logic [1:0]        op;
  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     msum;
  logic [DATA_W:0]     dshift;
  logic [DATA_W:0]     ddiff;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_c;
  logic [DATA_W-1:0]   quo_c;
  logic [DATA_W-1:0]   rem_c;
  logic [DATA_W-1:0]   res;

`ifdef MULDIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;
  logic q_neg_in;

  assign a_neg    = req_signed & req_a[DATA_W-1];
  assign b_neg    = req_signed & req_b[DATA_W-1];
  // a zero divisor keeps the all-ones quotient unsigned
  assign q_neg_in = (a_neg ^ b_neg) & (|req_b);
  assign mag_a    = a_neg ? -req_a : req_a;
  assign mag_b    = b_neg ? -req_b : req_b;
  assign prod_c   = neg_q ? -prod : prod;
  assign quo_c    = neg_q ? -lo : lo;
  assign rem_c    = neg_r ? -hi : hi;
`else
  logic unused_sgn;

  assign unused_sgn = req_signed;
  assign mag_a      = req_a;
  assign mag_b      = req_b;
  assign prod_c     = prod;
  assign quo_c      = lo;
  assign rem_c      = hi;
`endif

  // multiply: {hi,lo} holds the product with multiplier bits shifting out of lo
  assign msum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
  // divide: hi is the partial remainder, lo shifts dividend out / quotient in
  assign dshift = {hi, lo[DATA_W-1]};
  assign ddiff  = dshift - {1'b0, opb};
  assign prod   = {hi, lo};

  always_comb begin
    res = prod_c[DATA_W-1:0];
    unique case (op)
      2'b00:   res = prod_c[DATA_W-1:0];
      2'b01:   res = prod_c[2*DATA_W-1:DATA_W];
      2'b10:   res = quo_c;
      default: res = rem_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
      op        <= '0;
      dst       <= '0;
      opa       <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && !kill) begin
            state     <= CALC;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            op        <= req_op;
            dst       <= req_dst;
            opa       <= mag_a;
            opb       <= mag_b;
            hi        <= '0;
            lo        <= req_op[1] ? mag_a : mag_b;
            cnt       <= '0;
            fin       <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= q_neg_in;
            neg_r     <= a_neg;
`endif
          end
        end
        CALC: begin
          if (kill) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
          end else if (!fin) begin
            if (!op[1]) begin
              hi <= msum[DATA_W:1];
              lo <= {msum[0], lo[DATA_W-1:1]};
            end else begin
              hi <= ddiff[DATA_W] ? dshift[DATA_W-1:0]
                                  : ddiff[DATA_W-1:0];
              lo <= {lo[DATA_W-2:0], ~ddiff[DATA_W]};
            end
            if (cnt == LAST) begin
              fin <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (dst == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_addr  <= dst;
            wb_data  <= res;
          end
        end
        DONE: begin
          if (kill || wb_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            wb_valid  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          wb_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (DATA_W=32, ADDR_W=6).
// Signed cases run when MULDIV_SIGNED_EN is defined.
module tb_muldiv_unit;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic          req_signed;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [AW-1:0] req_dst;
  logic          kill;
  logic          busy;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] sbq[$];

  muldiv_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_signed(req_signed),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_dst   (req_dst),
    .kill      (kill),
    .busy      (busy),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] op,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sg);
    logic [63:0]        up;
    logic signed [63:0] sp;
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    logic [DW-1:0] minv;
    logic use_s;
    minv = '0;
    minv[DW-1] = 1'b1;
`ifdef MULDIV_SIGNED_EN
    use_s = sg;
`else
    use_s = 1'b0 & sg;
`endif
    sa = $signed(a);
    sb = $signed(b);
    up = {32'b0, a} * {32'b0, b};
    sp = $signed({{32{a[DW-1]}}, a}) * $signed({{32{b[DW-1]}}, b});
    case (op)
      OP_MUL:  model = use_s ? sp[31:0] : up[31:0];
      OP_MULH: model = use_s ? sp[63:32] : up[63:32];
      OP_DIV: begin
        if (b == 0) model = '1;
        else if (use_s && a == minv && b == '1) model = minv;
        else if (use_s) model = sa / sb;
        else model = a / b;
      end
      default: begin
        if (b == 0) model = a;
        else if (use_s && a == minv && b == '1) model = '0;
        else if (use_s) model = sa % sb;
        else model = a % b;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_beat", {58'b0, wb_addr}, 64'h0);
      end else begin
        logic [AW+DW-1:0] e;
        e = sbq.pop_front();
        chk("wb_addr", {58'b0, wb_addr}, {58'b0, e[AW+DW-1:DW]});
        chk("wb_data", {32'b0, wb_data}, {32'b0, e[DW-1:0]});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic [AW-1:0] dst, input logic sg);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {63'b0, req_ready}, 64'h1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    req_dst    = dst;
    req_signed = sg;
    if (dst != 0) sbq.push_back({dst, model(op, a, b, sg)});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {32'b0, sbq.size()}, 64'h0);
  endtask

  initial begin
    int k;
    int beats;
    logic [1:0]    rop;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    req_valid  = 1'b0;
    req_op     = '0;
    req_signed = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_dst    = '0;
    kill       = 1'b0;
    wb_ready   = 1'b1;
    rst_n      = 1'b1;
    #3 rst_n   = 1'b0;
    #2;
    chk("rst_req_ready", {63'b0, req_ready}, 64'h1);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_wb_valid", {63'b0, wb_valid}, 64'h0);
    chk("rst_wb_addr", {58'b0, wb_addr}, 64'h0);
    chk("rst_wb_data", {32'b0, wb_data}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // latency and ready timing on MUL 7*6
    issue(OP_MUL, 32'd7, 32'd6, 6'd2, 1'b0);
    k = 0;
    @(negedge clk);
    while (!wb_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("mul_latency", k, DW + 1);
    chk("ready_low_at_beat", {63'b0, req_ready}, 64'h0);
    @(negedge clk);
    chk("ready_after_beat", {63'b0, req_ready}, 64'h1);
    chk("valid_after_beat", {63'b0, wb_valid}, 64'h0);

    issue(OP_MULH, '1, '1, 6'd3, 1'b0);
    issue(OP_MUL, '1, '1, 6'd3, 1'b0);
    issue(OP_DIV, 32'd100, 32'd7, 6'd5, 1'b0);
    issue(OP_REM, 32'd100, 32'd7, 6'd5, 1'b0);
    issue(OP_DIV, 32'd25, 32'd0, 6'd5, 1'b0);
    issue(OP_REM, 32'd25, 32'd0, 6'd5, 1'b0);
    drain();

    // write-back backpressure
    wb_ready = 1'b0;
    issue(OP_DIV, 32'd50, 32'd5, 6'd1, 1'b0);
    k = 0;
    @(negedge clk);
    while (!wb_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'b0, wb_valid}, 64'h1);
      chk("bp_data", {32'b0, wb_data}, 64'd10);
      chk("bp_addr", {58'b0, wb_addr}, 64'd1);
      chk("bp_ready", {63'b0, req_ready}, 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", {63'b0, wb_valid}, 64'h0);
    chk("bp_idle_ready", {63'b0, req_ready}, 64'h1);

    // dst=0 raises no beat
    issue(OP_MUL, 32'd3, 32'd3, 6'd0, 1'b0);
    @(negedge clk);
    chk("dst0_busy_on", {63'b0, busy}, 64'h1);
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_valid) beats++;
    end
    chk("dst0_beats", beats, 0);
    chk("dst0_busy_off", {63'b0, busy}, 64'h0);

    // kill at iteration 10 of a DIV
    issue(OP_DIV, 32'd1000, 32'd3, 6'd4, 1'b0);
    void'(sbq.pop_back());
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_ready", {63'b0, req_ready}, 64'h1);
    chk("kill_busy", {63'b0, busy}, 64'h0);
    beats = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_valid) beats++;
    end
    chk("kill_beats", beats, 0);

    // kill in IDLE blocks acceptance
    @(negedge clk);
    kill      = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_dst   = 6'd7;
    @(posedge clk);
    #1;
    kill      = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_kill_busy", {63'b0, busy}, 64'h0);
    chk("idle_kill_ready", {63'b0, req_ready}, 64'h1);

    // async reset mid-calculation
    issue(OP_MUL, 32'd9, 32'd9, 6'd6, 1'b0);
    void'(sbq.pop_back());
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'b0, req_ready}, 64'h1);
    chk("mid_rst_busy", {63'b0, busy}, 64'h0);
    chk("mid_rst_valid", {63'b0, wb_valid}, 64'h0);
    chk("mid_rst_addr", {58'b0, wb_addr}, 64'h0);
    chk("mid_rst_data", {32'b0, wb_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_MUL, 32'd3, 32'd4, 6'd8, 1'b0);

`ifdef MULDIV_SIGNED_EN
    issue(OP_DIV, -32'sd7, 32'd2, 6'd10, 1'b1);
    issue(OP_REM, -32'sd7, 32'd2, 6'd10, 1'b1);
    issue(OP_MULH, '1, '1, 6'd11, 1'b1);
    issue(OP_DIV, 32'h8000_0000, '1, 6'd12, 1'b1);
    issue(OP_REM, 32'h8000_0000, '1, 6'd12, 1'b1);
    issue(OP_DIV, -32'sd25, 32'd0, 6'd13, 1'b1);
    issue(OP_REM, -32'sd25, 32'd0, 6'd13, 1'b1);
`else
    issue(OP_DIV, -32'sd7, 32'd2, 6'd10, 1'b1);
    issue(OP_MULH, '1, '1, 6'd11, 1'b1);
`endif

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
`ifdef MULDIV_SIGNED_EN
      issue(rop, ra, rb, 6'($urandom_range(1, 63)), 1'($urandom_range(0, 1)));
`else
      issue(rop, ra, rb, 6'($urandom_range(1, 63)), 1'b0);
`endif
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
